// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: two-flop synchroniser, start-bit qualification,
// mid-bit sampling, byte delivery with a valid pulse and stop-bit error flag.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 279,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_rx,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [8:0] BIT_LAST = 9'(CLKS_PER_BIT - 1);
  localparam logic [8:0] HALF_CNT = 9'(HALF_BIT);

  state_t      state_q;
  logic [8:0]  cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        err_q;
  logic        s1_q;
  logic        rx_s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      s1_q   <= rx;
      rx_s_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!rx_s_q) state_q <= S_START;
        end
        S_START: begin
          // A high sample anywhere before mid-start is treated as a glitch.
          if (rx_s_q) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == HALF_CNT) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s_q;
            if (idx_q == 3'd7) state_q <= S_STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        S_BREAK: begin
          // Wait out a held-low line so it is not decoded as repeated frames.
          cnt_q <= '0;
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign data_rx   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: an event-queue model predicts each frame's
// outcome and arrival window; a per-cycle compare process checks the outputs.
module tb_uart_receiver;

  localparam int CPB     = 279;
  localparam int LATENCY = 2 + 139 + 9 * 279;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data_rx;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_receiver dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data_rx  (data_rx),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         due;
  } ev_t;

  ev_t        expq[$];
  ev_t        ev_cur;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] model_data = 8'h00;
  logic       prev_pulse = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the event-queue model.
  always @(negedge clk) begin
    if (rst) begin
      chk("pulse_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
      chk("pulse_single_cycle", {31'd0, (rx_valid | frame_err) & prev_pulse}, 32'd0);
      prev_pulse = rx_valid | frame_err;
      if (rx_valid || frame_err) begin
        if (expq.size() == 0) begin
          chk("unexpected_pulse", {30'd0, rx_valid, frame_err}, 32'd0);
        end else begin
          ev_cur = expq.pop_front();
          chk("event_kind", {31'd0, frame_err}, {31'd0, ev_cur.is_err});
          chk("event_timing",
              {31'd0, (cyc >= ev_cur.due - 3) && (cyc <= ev_cur.due + 4)}, 32'd1);
          if (!ev_cur.is_err) begin
            model_data = ev_cur.data;
            $display("rx byte %02h at cycle %0d", data_rx, cyc);
          end else begin
            $display("framing error reported at cycle %0d", cyc);
          end
        end
      end else if (expq.size() != 0 && cyc > expq[0].due + 4) begin
        ev_cur = expq.pop_front();
        chk("missing_event", 32'd0, {24'd0, ev_cur.data});
      end
      chk("data_rx_model", {24'd0, data_rx}, {24'd0, model_data});
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    ev_t e;
    e.is_err = !stop_bit;
    e.data   = b;
    e.due    = cyc + LATENCY;
    expq.push_back(e);
    $display("send byte %02h stop=%0d at cycle %0d", b, stop_bit, cyc);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (expq.size() != 0 && waited < 4000) begin
      @(posedge clk);
      waited++;
    end
    #1;
    chk(name, expq.size(), 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int busy_low;
    logic [7:0] b;

    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_data_rx", {24'd0, data_rx}, 32'h00);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    idle(20);

    // Single byte
    send_frame(8'hA5, 1'b1);
    drain("drain_a5");
    chk("literal_a5", {24'd0, data_rx}, 32'hA5);
    idle(20);

    // Back-to-back, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    drain("drain_b2b");
    chk("literal_3c", {24'd0, data_rx}, 32'h3C);
    idle(20);

    // Glitch: 50 cycles low then high
    $display("glitch 50 cycles at cycle %0d", cyc);
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) rx = 1'b1;
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
    end
    chk("glitch_busy_len", {31'd0, (busy_cnt >= 47) && (busy_cnt <= 53)}, 32'd1);
    chk("glitch_busy_end", {31'd0, busy}, 32'd0);
    idle(20);

    // Framing error, then line held low
    send_frame(8'h55, 1'b0);
    busy_low = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (!busy) busy_low++;
    end
    chk("break_busy_held", busy_low, 32'd0);
    chk("ferr_data_kept", {24'd0, data_rx}, 32'h3C);
    idle(6);
    chk("break_released", {31'd0, busy}, 32'd0);
    drain("drain_ferr");
    idle(20);

    // Reset during bit 4 of 8'hC3
    $display("send byte c3 with reset in bit 4 at cycle %0d", cyc);
    b = 8'hC3;
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(b[i]);
    rx = b[4];
    repeat (140) @(posedge clk);
    #2;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    model_data = 8'h00;
    #1;
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_data", {24'd0, data_rx}, 32'h00);
    chk("async_reset_valid", {31'd0, rx_valid}, 32'd0);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(300);
    chk("post_reset_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b1);
    drain("drain_81");
    chk("literal_81", {24'd0, data_rx}, 32'h81);
    idle(20);

    // Loopback-style sweep across the byte range
    for (int v = 0; v < 256; v += 17) send_frame(8'(v), 1'b1);
    drain("drain_sweep");
    chk("literal_ff", {24'd0, data_rx}, 32'hFF);
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(95000 * 10);
    errors++;
    $display("FAIL global_timeout: got cycle %0d expected finish before 95000", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
